zap_wb_arbiter: RTL

Two-master, one-slave Wishbone classic arbiter for the ZAP simulation and SoC fabric. It merges the core's instruction and data Wishbone masters onto a single-port memory slave such as the RAM model. Arbitration is round-robin with per-cycle locking: a grant is held for the whole of the winning master's `cyc` assertion, so multi-beat cache-line transfers are never split.

---
 rtl/zap_wb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/zap_wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin priority.
// A grant is held for the full cyc assertion of the owning master.
module zap_wb_arbiter (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [31:0] i_m0_wb_adr,
    input  logic [31:0] i_m0_wb_dat,
    input  logic [3:0]  i_m0_wb_sel,
    output logic [31:0] o_m0_wb_dat,
    output logic        o_m0_wb_ack,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [31:0] i_m1_wb_adr,
    input  logic [31:0] i_m1_wb_dat,
    input  logic [3:0]  i_m1_wb_sel,
    output logic [31:0] o_m1_wb_dat,
    output logic        o_m1_wb_ack,

    output logic        o_s_wb_cyc,
    output logic        o_s_wb_stb,
    output logic        o_s_wb_we,
    output logic [31:0] o_s_wb_adr,
    output logic [31:0] o_s_wb_dat,
    output logic [3:0]  o_s_wb_sel,
    input  logic [31:0] i_s_wb_dat,
    input  logic        i_s_wb_ack,

    output logic [1:0]  o_gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state;
    logic       last;
    logic [1:0] gnt;

    // gnt is updated alongside state so it is always the registered decode of it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_wb_cyc && (!i_m1_wb_cyc || last)) begin
                        state <= GNT0;
                        gnt   <= 2'b01;
                    end else if (i_m1_wb_cyc) begin
                        state <= GNT1;
                        gnt   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!i_m0_wb_cyc) begin
                        last <= 1'b0;
                        if (i_m1_wb_cyc) begin
                            state <= GNT1;
                            gnt   <= 2'b10;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                GNT1: begin
                    if (!i_m1_wb_cyc) begin
                        last <= 1'b1;
                        if (i_m0_wb_cyc) begin
                            state <= GNT0;
                            gnt   <= 2'b01;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_s_wb_cyc = 1'b0;
        o_s_wb_stb = 1'b0;
        o_s_wb_we  = 1'b0;
        o_s_wb_adr = '0;
        o_s_wb_dat = '0;
        o_s_wb_sel = '0;
        case (state)
            GNT0: begin
                o_s_wb_cyc = i_m0_wb_cyc;
                o_s_wb_stb = i_m0_wb_stb;
                o_s_wb_we  = i_m0_wb_we;
                o_s_wb_adr = i_m0_wb_adr;
                o_s_wb_dat = i_m0_wb_dat;
                o_s_wb_sel = i_m0_wb_sel;
            end
            GNT1: begin
                o_s_wb_cyc = i_m1_wb_cyc;
                o_s_wb_stb = i_m1_wb_stb;
                o_s_wb_we  = i_m1_wb_we;
                o_s_wb_adr = i_m1_wb_adr;
                o_s_wb_dat = i_m1_wb_dat;
                o_s_wb_sel = i_m1_wb_sel;
            end
            default: ;
        endcase
    end

    // Gating with the master's own cyc drops a slave ack that races a release.
    assign o_m0_wb_ack = i_s_wb_ack && (state == GNT0) && i_m0_wb_cyc;
    assign o_m1_wb_ack = i_s_wb_ack && (state == GNT1) && i_m1_wb_cyc;

    assign o_m0_wb_dat = i_s_wb_dat;
    assign o_m1_wb_dat = i_s_wb_dat;
    assign o_gnt       = gnt;

endmodule
